// File: rtl/a2d_arbiter_if.sv
// Requester and A2D-side signals of the A2D arbiter. The slave modport is the
// arbiter's view; the master modport is the view of whatever drives it.
interface a2d_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  ch0;
  logic [2:0]  ch1;
  logic [2:0]  ch2;
  logic [2:0]  done;
  logic [2:0]  err;
  logic [11:0] res_out;
  logic        busy;
  logic [2:0]  a2d_chnnl;
  logic        a2d_strt_cnv;
  logic        a2d_cnv_cmplt;
  logic [11:0] a2d_res;

  modport slave (
    input  req, ch0, ch1, ch2, a2d_cnv_cmplt, a2d_res,
    output done, err, res_out, busy, a2d_chnnl, a2d_strt_cnv
  );

  modport master (
    output req, ch0, ch1, ch2, a2d_cnv_cmplt, a2d_res,
    input  done, err, res_out, busy, a2d_chnnl, a2d_strt_cnv
  );
endinterface

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter among three requesters, with a
// per-conversion timeout that reports err instead of done.
module a2d_arbiter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  a2d_arbiter_if.slave  bus
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state;
  logic [1:0]    owner, last_gnt, gnt;
  logic          gnt_vld;
  logic [2:0]    gnt_ch, req_m;
  logic [CW-1:0] cnt;
  logic [2:0]    chnnl, done_q, err_q;
  logic [11:0]   res_q;

  // The requester that just saw err still holds req this cycle; keep it out.
  assign req_m = bus.req & ~err_q;

  always_comb begin
    gnt     = 2'd0;
    gnt_vld = 1'b0;
    // Scan from lowest priority to highest so the last hit wins.
    for (int k = 3; k >= 1; k--) begin
      if (req_m[(int'(last_gnt) + k) % 3]) begin
        gnt     = 2'((int'(last_gnt) + k) % 3);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_ch = bus.ch0;
    case (gnt)
      2'd1:    gnt_ch = bus.ch1;
      2'd2:    gnt_ch = bus.ch2;
      default: gnt_ch = bus.ch0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 2'd0;
      last_gnt <= 2'd2;
      cnt      <= '0;
      chnnl    <= 3'd0;
      done_q   <= 3'd0;
      err_q    <= 3'd0;
      res_q    <= 12'd0;
    end else begin
      done_q <= 3'd0;
      err_q  <= 3'd0;
      case (state)
        IDLE: if (gnt_vld) begin
          owner <= gnt;
          chnnl <= gnt_ch;
          state <= START;
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion has priority over a coincident timeout.
          if (bus.a2d_cnv_cmplt) begin
            res_q  <= bus.a2d_res;
            done_q <= 3'b001 << owner;
            state  <= DONE;
          end else if (cnt == CNT_MAX) begin
            err_q    <= 3'b001 << owner;
            last_gnt <= owner;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          last_gnt <= owner;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.res_out      = res_q;
  assign bus.a2d_chnnl    = chnnl;
  assign bus.busy         = (state != IDLE);
  assign bus.a2d_strt_cnv = (state == START);
endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter: expected done/err pulses are queued when a
// request is raised and checked by a monitor when the pulse appears.
module tb_a2d_arbiter;
  logic clk;
  logic rst_n;
  a2d_arbiter_if bus();

  a2d_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  done;
    logic [2:0]  err;
    logic [11:0] res;
    logic [2:0]  chnl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int ndone  = 0;
  int nerr   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic [2:0] e, input logic [11:0] r,
                      input logic [2:0] c);
    exp_t x;
    x.done = d; x.err = e; x.res = r; x.chnl = c;
    sb.push_back(x);
  endtask

  task automatic wait_strobe(input string tag);
    int c;
    c = 0;
    while (!bus.a2d_strt_cnv && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(bus.a2d_strt_cnv), 32'd1);
  endtask

  // Called at the negedge of the strobe cycle or later; returns at the negedge of the done cycle.
  task automatic convert(input int lat, input logic [11:0] r);
    repeat (lat) @(negedge clk);
    bus.a2d_cnv_cmplt = 1'b1;
    bus.a2d_res       = r;
    @(negedge clk);
    bus.a2d_cnv_cmplt = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (bus.done != 3'd0 || bus.err != 3'd0)) begin
      if (bus.done != 3'd0) ndone++;
      if (bus.err != 3'd0) nerr++;
      if (sb.size() == 0) begin
        chk("sb_extra_pulse", 32'({bus.done, bus.err}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_done", 32'(bus.done), 32'(e.done));
        chk("sb_err", 32'(bus.err), 32'(e.err));
        chk("sb_res", 32'(bus.res_out), 32'(e.res));
        chk("sb_chnl", 32'(bus.a2d_chnnl), 32'(e.chnl));
      end
    end
  end

  initial begin
    logic [2:0]  rr_ch [3];
    logic [11:0] rr_res [3];
    rr_ch[0] = 3'd1; rr_ch[1] = 3'd5; rr_ch[2] = 3'd6;
    rr_res[0] = 12'h100; rr_res[1] = 12'h211; rr_res[2] = 12'h322;

    rst_n = 1'b0;
    bus.req = 3'b000; bus.ch0 = 3'd0; bus.ch1 = 3'd0; bus.ch2 = 3'd0;
    bus.a2d_cnv_cmplt = 1'b0; bus.a2d_res = 12'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_outs", 32'({bus.done, bus.err, bus.a2d_chnnl, bus.a2d_strt_cnv}), 32'd0);
    chk("rst_res", 32'(bus.res_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin from reset priority: 0, 1, 2
    bus.ch0 = rr_ch[0]; bus.ch1 = rr_ch[1]; bus.ch2 = rr_ch[2];
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) push(3'b001 << i, 3'b000, rr_res[i], rr_ch[i]);
    for (int i = 0; i < 3; i++) begin
      wait_strobe("rr_strobe");
      chk("rr_chnl", 32'(bus.a2d_chnnl), 32'(rr_ch[i]));
      if (i == 0) begin
        // completion flag during START must be ignored
        bus.a2d_cnv_cmplt = 1'b1; bus.a2d_res = 12'h999;
        @(negedge clk);
        bus.a2d_cnv_cmplt = 1'b0;
        chk("start_spur_busy", 32'(bus.busy), 32'd1);
        chk("start_spur_done", 32'(bus.done), 32'd0);
        convert(2, rr_res[i]);
      end else begin
        convert(3, rr_res[i]);
      end
      bus.req[i] = 1'b0;
    end
    @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 32'd0);

    // Single request, completion 10 cycles after the strobe
    bus.ch0 = 3'd3;
    chk("single_no_strb", 32'(bus.a2d_strt_cnv), 32'd0);
    bus.req = 3'b001;
    push(3'b001, 3'b000, 12'hABC, 3'd3);
    @(negedge clk);
    chk("single_strb", 32'(bus.a2d_strt_cnv), 32'd1);
    chk("single_chnl", 32'(bus.a2d_chnnl), 32'd3);
    convert(10, 12'hABC);
    chk("single_done", 32'(bus.done), 32'b001);
    bus.req = 3'b000;
    @(negedge clk);
    chk("single_done_1cyc", 32'(bus.done), 32'd0);
    chk("single_res", 32'(bus.res_out), 32'hABC);
    chk("single_idle", 32'(bus.busy), 32'd0);

    // Completion flag in IDLE
    bus.a2d_cnv_cmplt = 1'b1; bus.a2d_res = 12'h123;
    repeat (2) @(negedge clk);
    bus.a2d_cnv_cmplt = 1'b0;
    chk("idle_spur_busy", 32'(bus.busy), 32'd0);
    chk("idle_spur_res", 32'(bus.res_out), 32'hABC);
    chk("idle_chnl_hold", 32'(bus.a2d_chnnl), 32'd3);

    // Completion on the cycle the counter reaches TIMEOUT_CYC-1
    bus.ch0 = 3'd2;
    bus.req = 3'b001;
    push(3'b001, 3'b000, 12'h777, 3'd2);
    wait_strobe("simul_strobe");
    @(negedge clk);
    repeat (15) @(negedge clk);
    bus.a2d_cnv_cmplt = 1'b1; bus.a2d_res = 12'h777;
    @(negedge clk);
    bus.a2d_cnv_cmplt = 1'b0;
    chk("simul_done", 32'(bus.done), 32'b001);
    chk("simul_err0", 32'(bus.err), 32'd0);
    bus.req = 3'b000;
    @(negedge clk);
    chk("simul_err1", 32'(bus.err), 32'd0);

    // Timeout on requester 1
    bus.ch1 = 3'd4;
    bus.req = 3'b010;
    push(3'b000, 3'b010, 12'h777, 3'd4);
    wait_strobe("to_strobe");
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("to_early_err", 32'(bus.err), 32'd0);
    chk("to_early_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("to_err", 32'(bus.err), 32'b010);
    chk("to_nodone", 32'(bus.done), 32'd0);
    chk("to_idle", 32'(bus.busy), 32'd0);
    bus.req = 3'b000;
    @(negedge clk);
    chk("to_err_1cyc", 32'(bus.err), 32'd0);
    chk("to_no_regrant", 32'(bus.busy), 32'd0);
    chk("to_res", 32'(bus.res_out), 32'h777);

    // Reset mid-WAIT with requester 2 owning the converter
    bus.ch2 = 3'd3;
    bus.req = 3'b100;
    wait_strobe("rst_strobe");
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_outs", 32'({bus.done, bus.err, bus.a2d_chnnl, bus.a2d_strt_cnv}), 32'd0);
    chk("mid_rst_res", 32'(bus.res_out), 32'd0);
    bus.req = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.ch1 = 3'd7; bus.ch2 = 3'd1;
    bus.req = 3'b110;
    push(3'b010, 3'b000, 12'hDEF, 3'd7);
    push(3'b100, 3'b000, 12'hBBB, 3'd1);
    wait_strobe("post_rst_strobe1");
    chk("post_rst_first", 32'(bus.a2d_chnnl), 32'd7);
    convert(2, 12'hDEF);
    bus.req[1] = 1'b0;
    wait_strobe("post_rst_strobe2");
    chk("post_rst_second", 32'(bus.a2d_chnnl), 32'd1);
    convert(4, 12'hBBB);
    bus.req[2] = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(ndone), 32'd7);
    chk("err_count", 32'(nerr), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2d_arbiter.md
A2D_ARBITER -- requirements
Module: a2d_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: WAIT cycles allowed for a conversion before it is aborted.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req[2:0]  in  3  level request per requester (0 = slide scanner, 1 and 2 = auxiliary); held until done or err for that requester.
REQ-005 ch0/ch1/ch2  in  3 each  A2D channel requested by requester 0/1/2; stable while that req is high.
REQ-006 done[2:0]  out  3  one-cycle pulse to the served requester; res_out is valid in that cycle.
REQ-007 err[2:0]  out  3  one-cycle timeout pulse to the served requester.
REQ-008 res_out  out  12  registered result of the last completed conversion.
REQ-009 busy  out  1  high in START, WAIT and DONE.
REQ-010 a2d_chnnl  out  3  channel to the A2D interface.
REQ-011 a2d_strt_cnv  out  1  conversion start strobe to the A2D interface.
REQ-012 a2d_cnv_cmplt  in  1  conversion-complete flag from the A2D interface.
REQ-013 a2d_res  in  12  conversion result from the A2D interface.

Function
REQ-014 FSM states: IDLE, START, WAIT, DONE. Every output shall be registered or decoded from the state alone.
REQ-015 IDLE: when any req bit is high, the arbiter shall grant one requester round-robin, latch its index as owner, latch its channel into a2d_chnnl, and go to START.
REQ-016 Round-robin order: search begins at last_gnt+1 mod 3. Example: last_gnt=0 gives priority 1, 2, 0.
REQ-017 START: a2d_strt_cnv shall be high for exactly this one cycle. The timeout counter shall clear. The next state shall be WAIT.
REQ-018 a2d_strt_cnv shall be low in every state other than START.
REQ-019 WAIT with a2d_cnv_cmplt high: res_out shall load a2d_res, and the next state shall be DONE.
REQ-020 WAIT without completion: the counter shall increment. When the counter equals TIMEOUT_CYC-1, err[owner] shall pulse on the next cycle, res_out shall be unchanged, and the next state shall be IDLE.
REQ-021 Completion and timeout in the same cycle: completion shall win; err shall not pulse.
REQ-022 DONE: done[owner] shall be high for this one cycle. last_gnt shall load owner. The next state shall be IDLE.
REQ-023 On timeout, last_gnt shall also load owner.
REQ-024 a2d_chnnl shall be stable from START through DONE. It shall hold its last value in IDLE.
REQ-025 a2d_cnv_cmplt shall be ignored outside WAIT.
REQ-026 A request dropped during START or WAIT shall not abort the conversion; done still pulses.
REQ-027 A requester shall drop req on the cycle after seeing done or err.
REQ-028 Grant-to-strobe latency: req sampled high in IDLE gives a2d_strt_cnv high on the next cycle.
REQ-029 Minimum request-to-request turnaround shall be 4 cycles (IDLE, START, WAIT, DONE).
REQ-030 At most one bit of done shall be high in any cycle, and likewise for err; done and err shall never both be high.
REQ-031 The timeout counter shall be sized to hold TIMEOUT_CYC-1. It shall not wrap within one conversion.

Reset
REQ-032 While rst_n is low, the following shall hold regardless of clk:
- state = IDLE
- owner = 0
- last_gnt = 2, so requester 0 has first priority
- counter = 0
- a2d_chnnl = 0
- a2d_strt_cnv = 0
- done = 0, err = 0
- res_out = 0
- busy = 0
REQ-033 Reset asserted mid-conversion shall abandon it with no done or err pulse. After release, arbitration restarts from IDLE with the reset priority.

Verification
REQ-034 Single request: req=001, ch0=3; cnv_cmplt 10 cycles after strobe with a2d_res=0xABC. Required:
- a2d_chnnl=3
- one-cycle strt_cnv on the cycle after req is sampled
- done=001 for one cycle, res_out=0xABC.
REQ-035 Round-robin: req=111 held, each requester dropping after its done. Required:
- grants in order 0, 1, 2
- a2d_chnnl follows ch0, ch1, ch2
- exactly three done pulses.
REQ-036 Timeout: TIMEOUT_CYC=16, req=010, cnv_cmplt never asserted. Required:
- err=010 exactly 16 cycles after the WAIT entry cycle
- res_out unchanged, no done pulse
- return to IDLE.
REQ-037 Simultaneous events, TIMEOUT_CYC=16: cnv_cmplt asserted on the cycle the counter reaches 15. Required: done pulses, err stays 0.
REQ-038 Reset mid-WAIT: rst_n pulsed low while busy. Required:
- all outputs immediately 0
- no done or err pulse
- with req=110 after release, requester 1 is granted first.
REQ-039 Spurious cnv_cmplt in IDLE or START: no state change, no done, res_out unchanged.
